// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl
//   Sequencing controller for the 20 Hz keypad lock. Collects a 4-digit
//   code from the key scanner, checks it against the stored code, and owns
//   the entry timeout, result hold, failed-attempt lockout and code
//   programming.
//
// Ports
//   clk_20Hz     in   1   sole clock, rising edge
//   reset        in   1   synchronous, active-high
//   key_pressed  in   1   high while a key is held
//   key          in   4   hex code of the held key
//   digits       out  16  entered digits, [3:0] newest
//   digit_count  out  3   number of digits entered, 0..4
//   unlock_led   out  1   high in OPEN
//   error_led    out  1   high in DENIED and LOCKOUT
//   lockout      out  1   high in LOCKOUT
//   prog_mode    out  1   high in PROG
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for the first digit
// ENTRY    | collecting digits of an unlock attempt
// CHECK    | one cycle compare of entered digits against stored code
// OPEN     | code matched, unlock indication held; PROGRAM enters PROG
// DENIED   | code mismatched, error indication held
// LOCKOUT  | too many consecutive mismatches, all keys ignored
// PROG     | collecting a new code to store
module keypad_lock_ctrl #(
    parameter int          ENTRY_TIMEOUT = 300,
    parameter int          RESULT_TIME   = 100,
    parameter int          LOCKOUT_TIME  = 600,
    parameter int          MAX_FAILS     = 3,
    parameter logic [15:0] DEFAULT_CODE  = 16'h1234
) (
    input  logic        clk_20Hz,
    input  logic        reset,
    input  logic        key_pressed,
    input  logic [3:0]  key,
    output logic [15:0] digits,
    output logic [2:0]  digit_count,
    output logic        unlock_led,
    output logic        error_led,
    output logic        lockout,
    output logic        prog_mode
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_DENIED,
        S_LOCKOUT,
        S_PROG
    } state_t;

    localparam logic [15:0] ENTRY_LAST   = 16'(ENTRY_TIMEOUT - 1);
    localparam logic [15:0] RESULT_LAST  = 16'(RESULT_TIME - 1);
    localparam logic [15:0] LOCKOUT_LAST = 16'(LOCKOUT_TIME - 1);
    localparam logic [2:0]  FAIL_LIMIT   = 3'(MAX_FAILS);

    state_t      state;
    state_t      state_nxt;
    logic        kp_d;
    logic [15:0] timer;
    logic [15:0] code;
    logic [2:0]  fail_cnt;

    logic kev;
    logic k_digit;
    logic k_enter;
    logic k_clear;
    logic k_prog;
    logic digits_full;
    logic entry_expired;
    logic timer_restart;
    logic code_match;
    logic fail_last;

    // Rising edge of key_pressed: one event per press, no auto-repeat.
    assign kev     = key_pressed & ~kp_d;
    assign k_digit = kev & (key <= 4'h9);
    assign k_enter = kev & (key == 4'hA);
    assign k_clear = kev & (key == 4'hB);
    assign k_prog  = kev & (key == 4'hC);

    assign digits_full   = (digit_count == 3'd4);
    assign entry_expired = (timer == ENTRY_LAST);
    assign code_match    = (digits == code);
    assign fail_last     = ((fail_cnt + 3'd1) == FAIL_LIMIT);

    // Activity while entering a code keeps the entry alive, including a key
    // landing in the very cycle the timeout would otherwise fire.
    assign timer_restart = ((state == S_ENTRY) || (state == S_PROG)) &&
                           (k_digit || k_enter);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (k_digit) state_nxt = S_ENTRY;
            end
            S_ENTRY: begin
                if (k_clear)                              state_nxt = S_IDLE;
                else if (k_enter && digits_full)          state_nxt = S_CHECK;
                else if (entry_expired && !timer_restart) state_nxt = S_IDLE;
            end
            S_CHECK: begin
                if (code_match)     state_nxt = S_OPEN;
                else if (fail_last) state_nxt = S_LOCKOUT;
                else                state_nxt = S_DENIED;
            end
            S_OPEN: begin
                if (k_prog)                    state_nxt = S_PROG;
                else if (timer == RESULT_LAST) state_nxt = S_IDLE;
            end
            S_DENIED: begin
                if (timer == RESULT_LAST) state_nxt = S_IDLE;
            end
            S_LOCKOUT: begin
                if (timer == LOCKOUT_LAST) state_nxt = S_IDLE;
            end
            S_PROG: begin
                if (k_clear)                              state_nxt = S_IDLE;
                else if (k_enter && digits_full)          state_nxt = S_IDLE;
                else if (entry_expired && !timer_restart) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_20Hz) begin
        if (reset) begin
            state       <= S_IDLE;
            kp_d        <= 1'b0;
            timer       <= '0;
            code        <= DEFAULT_CODE;
            fail_cnt    <= '0;
            digits      <= '0;
            digit_count <= '0;
            unlock_led  <= 1'b0;
            error_led   <= 1'b0;
            lockout     <= 1'b0;
            prog_mode   <= 1'b0;
        end else begin
            kp_d  <= key_pressed;
            state <= state_nxt;

            // Up-counter cleared on every state entry; a timed state ends
            // when it reads LIMIT-1, giving exactly LIMIT cycles.
            if ((state_nxt != state) || timer_restart) timer <= '0;
            else                                       timer <= timer + 16'd1;

            unlock_led <= (state_nxt == S_OPEN);
            error_led  <= (state_nxt == S_DENIED) || (state_nxt == S_LOCKOUT);
            lockout    <= (state_nxt == S_LOCKOUT);
            prog_mode  <= (state_nxt == S_PROG);

            case (state)
                S_IDLE: begin
                    if (k_digit) begin
                        digits      <= {digits[11:0], key};
                        digit_count <= digit_count + 3'd1;
                    end
                end
                S_ENTRY, S_PROG: begin
                    // Every exit to IDLE (clear, timeout, stored code)
                    // discards the entered digits.
                    if (state_nxt == S_IDLE) begin
                        digits      <= '0;
                        digit_count <= '0;
                        if ((state == S_PROG) && k_enter && digits_full)
                            code <= digits;
                    end else if (k_digit && !digits_full) begin
                        digits      <= {digits[11:0], key};
                        digit_count <= digit_count + 3'd1;
                    end
                end
                S_CHECK: begin
                    digits      <= '0;
                    digit_count <= '0;
                    if (code_match)     fail_cnt <= '0;
                    else if (fail_last) fail_cnt <= FAIL_LIMIT;
                    else                fail_cnt <= fail_cnt + 3'd1;
                end
                S_LOCKOUT: begin
                    if (state_nxt == S_IDLE) fail_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
module tb_keypad_lock_ctrl;

    localparam int RESULT = 100;
    localparam int LOCK   = 600;
    localparam int TOUT   = 300;
    localparam int K_OPEN   = 0;
    localparam int K_DENIED = 1;
    localparam int K_LOCK   = 2;

    logic        clk;
    logic        reset;
    logic        key_pressed;
    logic [3:0]  key;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic        unlock_led;
    logic        error_led;
    logic        lockout;
    logic        prog_mode;

    keypad_lock_ctrl dut (
        .clk_20Hz    (clk),
        .reset       (reset),
        .key_pressed (key_pressed),
        .key         (key),
        .digits      (digits),
        .digit_count (digit_count),
        .unlock_led  (unlock_led),
        .error_led   (error_led),
        .lockout     (lockout),
        .prog_mode   (prog_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          cyc;
        logic [22:0] val;
    } exp_t;

    exp_t        sb[$];
    int          cyc    = 0;
    int          tp     = 0;
    int          n_cmp  = 0;
    int          n_err  = 0;
    bit          mon_en = 1'b0;
    logic [22:0] obs;
    logic [22:0] prev   = '1;

    assign obs = {digits, digit_count, unlock_led, error_led, lockout, prog_mode};

    // Monitor: every change of the output vector is one DUT response and is
    // matched against the next expected response, both value and cycle.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_en) begin
            if (obs !== prev) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_change cyc=%0d got=%h expected no change from %h", cyc, obs, prev);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_cmp++;
                    if (obs !== e.val) begin
                        n_err++;
                        $display("FAIL %s value cyc=%0d got=%h expected=%h", e.nm, cyc, obs, e.val);
                    end
                    n_cmp++;
                    if (cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL %s timing got cyc=%0d expected cyc=%0d", e.nm, cyc, e.cyc);
                    end
                end
                prev = obs;
            end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++; n_err++;
                $display("FAIL %s missing at cyc=%0d got=%h expected=%h", e.nm, e.cyc, obs, e.val);
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog cyc=%0d got no end of stimulus expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic arm();
        @(negedge clk);
        tp = cyc;
    endtask

    task automatic exp(input string nm, input int dt, input logic [15:0] d,
                       input int cnt, input bit u, input bit e, input bit l, input bit p);
        exp_t x;
        x.nm  = nm;
        x.cyc = tp + dt;
        x.val = {d, 3'(cnt), u, e, l, p};
        sb.push_back(x);
    endtask

    // Drives at the current falling edge, holds, releases, then leaves a gap.
    task automatic press(input logic [3:0] k, input int hold);
        key_pressed = 1'b1;
        key         = k;
        repeat (hold) @(negedge clk);
        key_pressed = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic enter_digits(input logic [15:0] c, input bit p);
        logic [15:0] acc;
        logic [3:0]  k;
        acc = '0;
        for (int i = 3; i >= 0; i--) begin
            k   = c[i*4 +: 4];
            acc = {acc[11:0], k};
            arm();
            exp("digit", 1, acc, 4 - i, 1'b0, 1'b0, 1'b0, p);
            press(k, 1);
        end
    endtask

    task automatic submit(input int kind, input bit push_end, output int t_enter);
        arm();
        t_enter = tp;
        case (kind)
            K_OPEN: begin
                exp("open", 2, 16'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
                if (push_end) exp("open_end", 2 + RESULT, 16'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            K_DENIED: begin
                exp("denied", 2, 16'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
                if (push_end) exp("denied_end", 2 + RESULT, 16'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            default: begin
                exp("lockout", 2, 16'h0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
                if (push_end) exp("lockout_end", 2 + LOCK, 16'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        endcase
        press(4'hA, 1);
    endtask

    initial begin
        int t;
        reset       = 1'b1;
        key_pressed = 1'b0;
        key         = 4'h0;
        repeat (3) @(negedge clk);
        arm();
        exp("reset", 1, 16'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Default code opens
        enter_digits(16'h1234, 1'b0);
        submit(K_OPEN, 1'b1, t);
        wait_until(t + RESULT + 5);

        // Three wrong codes: two denials then lockout; keys ignored meanwhile
        enter_digits(16'h5555, 1'b0);
        submit(K_DENIED, 1'b1, t);
        press(4'h1, 1);
        press(4'hC, 1);
        wait_until(t + RESULT + 5);
        enter_digits(16'h5555, 1'b0);
        submit(K_DENIED, 1'b1, t);
        wait_until(t + RESULT + 5);
        enter_digits(16'h5555, 1'b0);
        submit(K_LOCK, 1'b1, t);
        press(4'h1, 1);
        press(4'h2, 1);
        press(4'hA, 1);
        press(4'hC, 1);
        press(4'hB, 1);
        press(4'hD, 1);
        wait_until(t + LOCK + 5);
        enter_digits(16'h1234, 1'b0);
        submit(K_OPEN, 1'b1, t);
        wait_until(t + RESULT + 5);

        // Held key shifts once; fifth digit ignored; CLEAR
        arm(); exp("hold7", 1, 16'h0007, 1, 1'b0, 1'b0, 1'b0, 1'b0); press(4'h7, 10);
        arm(); exp("d8", 1, 16'h0078, 2, 1'b0, 1'b0, 1'b0, 1'b0); press(4'h8, 1);
        arm(); exp("d9", 1, 16'h0789, 3, 1'b0, 1'b0, 1'b0, 1'b0); press(4'h9, 1);
        arm(); exp("d6", 1, 16'h7896, 4, 1'b0, 1'b0, 1'b0, 1'b0); press(4'h6, 1);
        press(4'h5, 1);
        arm(); exp("clear", 1, 16'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0); press(4'hB, 1);

        // One failure, timeout, then exactly two more failures to lock out
        enter_digits(16'h5555, 1'b0);
        submit(K_DENIED, 1'b1, t);
        wait_until(t + RESULT + 5);
        arm();
        exp("one", 1, 16'h0001, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp("timeout", 1 + TOUT, 16'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        t = tp;
        press(4'h1, 1);
        wait_until(t + TOUT + 5);
        enter_digits(16'h5555, 1'b0);
        submit(K_DENIED, 1'b1, t);
        wait_until(t + RESULT + 5);
        enter_digits(16'h5555, 1'b0);
        submit(K_LOCK, 1'b0, t);

        // Reset in the middle of lockout
        wait_until(t + 2 + 249);
        arm();
        exp("lock_reset", 1, 16'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // D/E/F ignored in IDLE and ENTRY
        press(4'hD, 1);
        press(4'hE, 1);
        press(4'hF, 1);
        arm(); exp("d1", 1, 16'h0001, 1, 1'b0, 1'b0, 1'b0, 1'b0); press(4'h1, 1);
        press(4'hE, 1);
        press(4'hF, 1);
        press(4'hD, 1);
        arm(); exp("clear2", 1, 16'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0); press(4'hB, 1);

        // fail count was cleared by reset: two failures both deny
        enter_digits(16'h5555, 1'b0);
        submit(K_DENIED, 1'b1, t);
        wait_until(t + RESULT + 5);
        enter_digits(16'h5555, 1'b0);
        submit(K_DENIED, 1'b1, t);
        wait_until(t + RESULT + 5);

        // Programming a new code, then reset restores the default
        enter_digits(16'h1234, 1'b0);
        submit(K_OPEN, 1'b0, t);
        arm(); exp("prog", 1, 16'h0, 0, 1'b0, 1'b0, 1'b0, 1'b1); press(4'hC, 1);
        enter_digits(16'h9876, 1'b1);
        arm(); exp("prog_store", 1, 16'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0); press(4'hA, 1);
        enter_digits(16'h1234, 1'b0);
        submit(K_DENIED, 1'b1, t);
        wait_until(t + RESULT + 5);
        enter_digits(16'h9876, 1'b0);
        submit(K_OPEN, 1'b1, t);
        wait_until(t + RESULT + 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        enter_digits(16'h1234, 1'b0);
        submit(K_OPEN, 1'b1, t);
        wait_until(t + RESULT + 5);

        repeat (5) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL leftover got %0d pending responses expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
